// File: rtl/sfu_pkg.sv
// Shared SFU definitions: bank geometry, psum lane types and the
// drain FSM state encoding used by the psum read-out path.
package sfu_pkg;

    localparam int NUM_CH  = 8;
    localparam int NUM_PIX = 16;
    localparam int PSUM_BW = 16;
    localparam int ADDR_W  = 11;

    localparam int IDX_W  = $clog2(NUM_PIX);
    localparam int CNT_W  = $clog2(NUM_PIX + 1);
    localparam int WORD_W = NUM_CH * PSUM_BW;

    typedef logic signed [PSUM_BW-1:0] psum_t;
    typedef psum_t psum_word_t [NUM_CH];

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } drain_state_e;

endpackage

// File: rtl/psum_relu.sv
// Per-lane ReLU over one bank word; negative lanes clamp to 0 when
// relu_en is set. Ports: relu_en, din (packed word), dout (packed word).
module psum_relu
    import sfu_pkg::*;
(
    input  logic              relu_en,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    psum_word_t lane;

    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            lane[i] = psum_t'(din[i*PSUM_BW +: PSUM_BW]);
            if (relu_en && lane[i][PSUM_BW-1]) begin
                dout[i*PSUM_BW +: PSUM_BW] = '0;
            end else begin
                dout[i*PSUM_BW +: PSUM_BW] = lane[i];
            end
        end
    end

endmodule

// File: rtl/psum_drain.sv
// Walks the SFU psum bank pixel by pixel and streams ReLU'd words to the
// output SRAM over valid/ready; pulses done/bank_clr after the last word.
// Ports: clk, reset, start, base_addr, relu_en, bank_idx, bank_data,
//        o_valid, o_ready, o_addr, o_data, busy, done, bank_clr.
module psum_drain
    import sfu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              relu_en,
    output logic [IDX_W-1:0]  bank_idx,
    input  logic [WORD_W-1:0] bank_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [WORD_W-1:0] o_data,
    output logic              busy,
    output logic              done,
    output logic              bank_clr
);

    drain_state_e      state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              relu_q, relu_d;
    logic              o_valid_q, o_valid_d;
    logic [ADDR_W-1:0] o_addr_q, o_addr_d;
    logic [WORD_W-1:0] o_data_q, o_data_d;
    logic [WORD_W-1:0] relu_word;
    logic              hs;

    psum_relu u_relu (
        .relu_en (relu_q),
        .din     (bank_data),
        .dout    (relu_word)
    );

    assign hs = o_valid_q & o_ready;

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        base_d    = base_q;
        relu_d    = relu_q;
        o_valid_d = o_valid_q;
        o_addr_d  = o_addr_q;
        o_data_d  = o_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_FILL;
                    base_d    = base_addr;
                    relu_d    = relu_en;
                    pix_cnt_d = '0;
                end
            end
            S_FILL: begin
                o_data_d  = relu_word;
                o_addr_d  = base_q;
                o_valid_d = 1'b1;
                pix_cnt_d = CNT_W'(1);
                state_d   = (NUM_PIX == 1) ? S_FLUSH : S_STREAM;
            end
            S_STREAM: begin
                // bank_idx tracks pix_cnt, so a stall holds the read index
                if (hs) begin
                    o_data_d  = relu_word;
                    o_addr_d  = base_q + ADDR_W'(pix_cnt_q);
                    pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    if (pix_cnt_q == CNT_W'(NUM_PIX - 1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (hs) begin
                    o_valid_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                pix_cnt_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            base_q    <= '0;
            relu_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_addr_q  <= '0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            base_q    <= base_d;
            relu_q    <= relu_d;
            o_valid_q <= o_valid_d;
            o_addr_q  <= o_addr_d;
            o_data_q  <= o_data_d;
        end
    end

    assign bank_idx = pix_cnt_q[IDX_W-1:0];
    assign o_valid  = o_valid_q;
    assign o_addr   = o_addr_q;
    assign o_data   = o_data_q;
    assign busy     = (state_q == S_FILL) || (state_q == S_STREAM) ||
                      (state_q == S_FLUSH);
    assign done     = (state_q == S_DONE);
    assign bank_clr = (state_q == S_DONE);

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: a queue of expected words built from
// the bank contents, checked every cycle, plus directed literal checks.
module tb_psum_drain;
    import sfu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [10:0]  base_addr;
    logic         relu_en;
    logic [3:0]   bank_idx;
    logic [127:0] bank_data;
    logic         o_valid;
    logic         o_ready;
    logic [10:0]  o_addr;
    logic [127:0] o_data;
    logic         busy;
    logic         done;
    logic         bank_clr;

    psum_drain dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .relu_en   (relu_en),
        .bank_idx  (bank_idx),
        .bank_data (bank_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_addr    (o_addr),
        .o_data    (o_data),
        .busy      (busy),
        .done      (done),
        .bank_clr  (bank_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] bank [16][8];

    always_comb begin
        bank_data = '0;
        for (int c = 0; c < 8; c++) begin
            bank_data[c*16 +: 16] = bank[bank_idx][c];
        end
    end

    typedef struct {
        logic [10:0]  addr;
        logic [127:0] data;
        int           pix;
    } exp_t;

    exp_t expq[$];

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int clr_cnt = 0;
    int last_done_cyc = -1;
    int first_valid_cyc = -1;

    logic [10:0]  snap_addr;
    logic [127:0] snap_data;
    logic [10:0]  snap_addr2;
    logic [3:0]   snap_idx;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model_word(input int p, input bit relu);
        logic [127:0] w;
        logic [15:0]  v;
        w = '0;
        for (int c = 0; c < 8; c++) begin
            v = bank[p][c];
            if (relu && v[15]) v = 16'h0000;
            w[c*16 +: 16] = v;
        end
        return w;
    endfunction

    task automatic fill_bank(input bit neg);
        for (int p = 0; p < 16; p++) begin
            for (int c = 0; c < 8; c++) begin
                bank[p][c] = 16'(p * 16 + c);
            end
        end
        if (neg) begin
            bank[5][3] = 16'hFFF9;
            bank[5][4] = 16'h0009;
            for (int p = 0; p < 16; p++) begin
                bank[p][7] = 16'(-(p + 1));
            end
        end
    endtask

    task automatic load_model(input logic [10:0] base, input bit relu);
        exp_t e;
        for (int p = 0; p < 16; p++) begin
            e.addr = 11'(base + 11'(p));
            e.data = model_word(p, relu);
            e.pix  = p;
            expq.push_back(e);
        end
    endtask

    // Compare process: every output word presented must be the next word
    // the model expects; a handshake retires it.
    always @(negedge clk) begin
        if (!reset) begin
            if (o_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (expq.size() == 0) begin
                    chk("spurious_valid", 128'(o_valid), 128'(0));
                end else begin
                    chk("o_addr", 128'(o_addr), 128'(expq[0].addr));
                    chk("o_data", o_data, expq[0].data);
                    if (expq[0].pix < 15) begin
                        chk("bank_idx", 128'(bank_idx),
                            128'(expq[0].pix + 1));
                    end
                    if (o_ready) void'(expq.pop_front());
                end
            end
            chk("clr_eq_done", 128'(bank_clr), 128'(done));
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_q_empty", 128'(expq.size()), 128'(0));
                chk("done_busy", 128'(busy), 128'(0));
            end
            if (bank_clr) clr_cnt++;
        end
    end

    task automatic run_drain(input logic [10:0] base, input bit relu,
                             input int stall_at, input int restart_at,
                             input int exp_lat);
        int t;
        int d0;
        int c0;
        d0 = done_cnt;
        c0 = clr_cnt;
        load_model(base, relu);
        tick();
        start = 1'b1;
        base_addr = base;
        relu_en = relu;
        t = cyc;
        first_valid_cyc = -1;
        for (int k = 0; k < 80 && done_cnt == d0; k++) begin
            tick();
            start = 1'b0;
            if (restart_at >= 0 && cyc == t + restart_at) begin
                start = 1'b1;
                base_addr = 11'h7F0;
                relu_en = ~relu;
            end
            o_ready = !(stall_at >= 0 && cyc >= t + 2 + stall_at &&
                        cyc < t + 5 + stall_at);
            if (cyc == t + 1) chk("busy_after_start", 128'(busy), 128'(1));
            if (cyc == t + 7) begin
                snap_addr = o_addr;
                snap_data = o_data;
            end
            if (cyc == t + 11) begin
                snap_addr2 = o_addr;
                snap_idx = bank_idx;
            end
        end
        start = 1'b0;
        o_ready = 1'b1;
        chk("done_seen", 128'(done_cnt - d0), 128'(1));
        chk("first_valid_lat", 128'(first_valid_cyc - t), 128'(2));
        chk("done_lat", 128'(last_done_cyc - t), 128'(exp_lat));
        chk("clr_pulses", 128'(clr_cnt - c0), 128'(1));
        repeat (4) tick();
        chk("single_done", 128'(done_cnt - d0), 128'(1));
        chk("queue_drained", 128'(expq.size()), 128'(0));
    endtask

    task automatic reset_mid_drain(input logic [10:0] base);
        int t;
        int d0;
        int c0;
        d0 = done_cnt;
        c0 = clr_cnt;
        load_model(base, 1'b0);
        tick();
        start = 1'b1;
        base_addr = base;
        relu_en = 1'b0;
        t = cyc;
        for (int k = 0; k < 40 && cyc < t + 11; k++) begin
            tick();
            start = 1'b0;
        end
        chk("rst_at_word9", 128'(o_addr), 128'(11'(base + 11'd9)));
        reset = 1'b1;
        expq.delete();
        @(negedge clk);
        chk("rst_valid_low", 128'(o_valid), 128'(0));
        chk("rst_busy_low", 128'(busy), 128'(0));
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_no_clr", 128'(clr_cnt - c0), 128'(0));
        chk("rst_no_done", 128'(done_cnt - d0), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        relu_en = 1'b0;
        o_ready = 1'b1;
        base_addr = '0;
        fill_bank(1'b0);
        repeat (3) tick();
        reset = 1'b0;

        repeat (10) begin
            @(negedge clk);
            chk("idle_ctl",
                128'({o_valid, busy, done, bank_clr, bank_idx, o_addr}),
                128'(0));
            chk("idle_data", o_data, 128'(0));
        end
        tick();

        run_drain(11'h040, 1'b0, -1, -1, 18);
        chk("lit_w5_addr", 128'(snap_addr), 128'(11'h045));
        chk("lit_w5_l3", 128'(snap_data[63:48]), 128'(16'h0053));

        fill_bank(1'b1);
        run_drain(11'h100, 1'b1, -1, -1, 18);
        chk("lit_relu_l3", 128'(snap_data[63:48]), 128'(16'h0000));
        chk("lit_relu_l4", 128'(snap_data[79:64]), 128'(16'h0009));
        run_drain(11'h100, 1'b0, -1, -1, 18);
        chk("lit_norelu_l3", 128'(snap_data[63:48]), 128'(16'hFFF9));
        chk("lit_norelu_l4", 128'(snap_data[79:64]), 128'(16'h0009));

        fill_bank(1'b0);
        run_drain(11'h040, 1'b0, 7, -1, 21);
        chk("lit_stall_addr", 128'(snap_addr2), 128'(11'h047));
        chk("lit_stall_idx", 128'(snap_idx), 128'(8));

        run_drain(11'h040, 1'b0, -1, 5, 18);

        run_drain(11'h7F8, 1'b0, -1, -1, 18);
        chk("lit_wrap_w5", 128'(snap_addr), 128'(11'h7FD));

        reset_mid_drain(11'h040);
        run_drain(11'h040, 1'b0, -1, -1, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
